// File: rtl/spi_flash_resp_if.sv
// Bundles the SPI serial pins and the word-memory read port of the
// spi_flash_resp block; the slave modport is the responder's view.
interface spi_flash_resp_if #(
  parameter int ADDR_W = 24
);
  logic              spi_sck;
  logic              spi_ss;
  logic              spi_mosi;
  logic              spi_miso;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;

  modport slave (
    input  spi_sck,
    input  spi_ss,
    input  spi_mosi,
    input  mem_rdata,
    output spi_miso,
    output mem_en,
    output mem_addr
  );

  modport master (
    output spi_sck,
    output spi_ss,
    output spi_mosi,
    output mem_rdata,
    input  spi_miso,
    input  mem_en,
    input  mem_addr
  );
endinterface

// File: rtl/spi_flash_resp.sv
// SPI mode-0 serial-flash read responder. Decodes a READ opcode plus an
// address, fetches 32-bit words from a backing memory and streams them
// out on MISO in flash byte order, refetching the next word seamlessly.
module spi_flash_resp #(
  parameter logic [7:0] CMD_READ = 8'h03,
  parameter int         ADDR_W   = 24
) (
  input  logic                    clock,
  input  logic                    reset,
  spi_flash_resp_if.slave         bus,
  output logic                    busy,
  output logic                    cmd_err
);

  localparam int MAX_BITS = (ADDR_W > 32) ? ADDR_W : 32;
  localparam int CNT_W    = $clog2(MAX_BITS) + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    FETCH  = 3'd3,
    DATA   = 3'd4,
    IGNORE = 3'd5
  } state_t;

  // Memory word little-endian bytes become a big-endian shift image, so
  // shifting MSB-first emits byte 0 first, each byte MSB-first.
  function automatic logic [31:0] flash_order(input logic [31:0] w);
    flash_order = {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Synchroniser and edge-detect registers
  logic ss_s1_q, ss_s2_q, ss_prev_q;
  logic sck_s1_q, sck_s2_q, sck_prev_q;
  logic mosi_s1_q, mosi_s2_q;
  logic [1:0] fill_q;
  logic       armed_q;
  logic       armed_d;

  // Protocol state
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       shift_q, shift_d;
  logic              fetch_ph_q, fetch_ph_d;

  // Registered outputs
  logic              miso_q, miso_d;
  logic              mem_en_q, mem_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              busy_q, busy_d;
  logic              cmd_err_q, cmd_err_d;

  logic sck_rise_s, sck_fall_s, ss_rise_s, ss_fall_s;

  // Edges come from the synchronised level and its one-cycle-old copy.
  // A select edge is only honoured once a genuine high ss level has been
  // sampled since reset, so a line held low across reset cannot start a
  // transfer by itself.
  assign sck_rise_s = sck_s2_q & ~sck_prev_q;
  assign sck_fall_s = ~sck_s2_q & sck_prev_q;
  assign ss_rise_s  = ss_s2_q & ~ss_prev_q;
  assign ss_fall_s  = ~ss_s2_q & ss_prev_q & armed_q;
  assign armed_d    = armed_q | (fill_q[1] & ss_s2_q);

  // Two-flop synchronisers, edge history and select arming
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ss_s1_q    <= 1'b1;
      ss_s2_q    <= 1'b1;
      ss_prev_q  <= 1'b1;
      sck_s1_q   <= 1'b0;
      sck_s2_q   <= 1'b0;
      sck_prev_q <= 1'b0;
      mosi_s1_q  <= 1'b0;
      mosi_s2_q  <= 1'b0;
      fill_q     <= 2'b00;
      armed_q    <= 1'b0;
    end else begin
      ss_s1_q    <= bus.spi_ss;
      ss_s2_q    <= ss_s1_q;
      ss_prev_q  <= ss_s2_q;
      sck_s1_q   <= bus.spi_sck;
      sck_s2_q   <= sck_s1_q;
      sck_prev_q <= sck_s2_q;
      mosi_s1_q  <= bus.spi_mosi;
      mosi_s2_q  <= mosi_s1_q;
      fill_q     <= {fill_q[0], 1'b1};
      armed_q    <= armed_d;
    end
  end

  // Next-state, datapath and output decode; deselect outranks any sck edge
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    shift_d    = shift_q;
    fetch_ph_d = fetch_ph_q;
    cmd_err_d  = 1'b0;
    mem_en_d   = 1'b0;

    if (ss_rise_s) begin
      state_d    = IDLE;
      cnt_d      = '0;
      fetch_ph_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ss_fall_s) begin
            state_d = CMD;
            cnt_d   = '0;
            cmd_d   = 8'h00;
          end else begin
            state_d = IDLE;
          end
        end
        CMD: begin
          if (sck_rise_s) begin
            cmd_d = {cmd_q[6:0], mosi_s2_q};
            if (cnt_q == CNT_W'(7)) begin
              cnt_d = '0;
              if (cmd_d == CMD_READ) begin
                state_d = ADDR;
              end else begin
                state_d   = IGNORE;
                cmd_err_d = 1'b1;
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            state_d = CMD;
          end
        end
        ADDR: begin
          if (sck_rise_s) begin
            addr_d = {addr_q[ADDR_W-2:0], mosi_s2_q};
            if (cnt_q == CNT_W'(ADDR_W - 1)) begin
              cnt_d      = '0;
              state_d    = FETCH;
              fetch_ph_d = 1'b0;
              mem_en_d   = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            state_d = ADDR;
          end
        end
        FETCH: begin
          // Phase 0 carries the mem_en strobe; phase 1 sees valid rdata.
          if (fetch_ph_q == 1'b0) begin
            fetch_ph_d = 1'b1;
          end else begin
            fetch_ph_d = 1'b0;
            shift_d    = flash_order(bus.mem_rdata);
            cnt_d      = '0;
            state_d    = DATA;
          end
        end
        DATA: begin
          // cnt counts bits the master has sampled in the current word; the
          // fall that follows the load presents bit 0 and must not shift.
          if (sck_rise_s) begin
            if (cnt_q == CNT_W'(31)) begin
              cnt_d      = '0;
              addr_d     = {addr_q[ADDR_W-1:2], 2'b00} + ADDR_W'(4);
              state_d    = FETCH;
              fetch_ph_d = 1'b0;
              mem_en_d   = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (sck_fall_s && (cnt_q != '0)) begin
            shift_d = {shift_q[30:0], 1'b0};
          end else begin
            state_d = DATA;
          end
        end
        IGNORE: begin
          state_d = IGNORE;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    if (mem_en_d) begin
      mem_addr_d = {addr_d[ADDR_W-1:2], 2'b00};
    end else begin
      mem_addr_d = mem_addr_q;
    end

    if (state_d == DATA) begin
      miso_d = shift_d[31];
    end else begin
      miso_d = 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

  // State, datapath and registered output flops
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cmd_q      <= 8'h00;
      addr_q     <= '0;
      shift_q    <= 32'h0000_0000;
      fetch_ph_q <= 1'b0;
      miso_q     <= 1'b1;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      busy_q     <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      shift_q    <= shift_d;
      fetch_ph_q <= fetch_ph_d;
      miso_q     <= miso_d;
      mem_en_q   <= mem_en_d;
      mem_addr_q <= mem_addr_d;
      busy_q     <= busy_d;
      cmd_err_q  <= cmd_err_d;
    end
  end

  assign bus.spi_miso = miso_q;
  assign bus.mem_en   = mem_en_q;
  assign bus.mem_addr = mem_addr_q;
  assign busy         = busy_q;
  assign cmd_err      = cmd_err_q;

endmodule

// File: tb/tb_spi_flash_resp.sv
// Directed bench for spi_flash_resp: a mode-0 SPI master at clock/8 and a
// one-cycle-latency word memory with hand-chosen contents.
module tb_spi_flash_resp;

  logic clock;
  logic reset;
  logic busy;
  logic cmd_err;

  spi_flash_resp_if #(.ADDR_W(24)) bus ();

  spi_flash_resp #(.CMD_READ(8'h03), .ADDR_W(24)) dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus),
    .busy    (busy),
    .cmd_err (cmd_err)
  );

  int n_vec  = 0;
  int n_miss = 0;
  int en_cnt = 0;
  int err_cnt = 0;
  logic [23:0] addr_log [64];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] word_at(input logic [23:0] a);
    case (a)
      24'h000004: word_at = 32'hDDCCBBAA;
      24'h000008: word_at = 32'h44332211;
      24'hFFFFFC: word_at = 32'h87654321;
      24'h000000: word_at = 32'h0FEDCBA9;
      24'h000010: word_at = 32'hA5C33C5A;
      default:    word_at = 32'hDEADBEEF;
    endcase
  endfunction

  // Backing memory: data valid the cycle after the strobe
  always_ff @(posedge clock) begin
    if (bus.mem_en) bus.mem_rdata <= word_at(bus.mem_addr);
  end

  // Strobe / error monitor
  always_ff @(posedge clock) begin
    if (bus.mem_en) begin
      addr_log[en_cnt[5:0]] <= bus.mem_addr;
      en_cnt <= en_cnt + 1;
    end
    if (cmd_err) err_cnt <= err_cnt + 1;
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Mode 0: drive MOSI with sck low, sample MISO just before the rise
  task automatic spi_xfer(input logic [31:0] tx, input int n, output logic [31:0] rx);
    rx = 32'h0;
    for (int i = n - 1; i >= 0; i--) begin
      bus.spi_mosi = tx[i];
      repeat (4) @(negedge clock);
      rx = {rx[30:0], bus.spi_miso};
      bus.spi_sck = 1'b1;
      repeat (4) @(negedge clock);
      bus.spi_sck = 1'b0;
    end
  endtask

  task automatic select();
    bus.spi_ss = 1'b0;
    repeat (8) @(negedge clock);
  endtask

  task automatic deselect();
    repeat (4) @(negedge clock);
    bus.spi_ss = 1'b1;
    repeat (10) @(negedge clock);
  endtask

  // Read nbytes and compare against the bytes of exp, first byte in [63:56]
  task automatic read_check(input string tag, input logic [63:0] exp, input int nbytes);
    logic [31:0] rx;
    for (int b = 0; b < nbytes; b++) begin
      spi_xfer(32'h0, 8, rx);
      check_vec(tag, rx, {24'h0, exp[63 - 8*b -: 8]});
    end
  endtask

  initial begin
    logic [31:0] rx;
    int base;
    int ebase;

    reset        = 1'b0;
    bus.spi_sck  = 1'b0;
    bus.spi_ss   = 1'b1;
    bus.spi_mosi = 1'b0;
    repeat (4) @(negedge clock);
    check_vec("rst_miso",    {31'h0, bus.spi_miso}, 32'h1);
    check_vec("rst_busy",    {31'h0, busy},         32'h0);
    check_vec("rst_mem_en",  {31'h0, bus.mem_en},   32'h0);
    check_vec("rst_addr",    {8'h0, bus.mem_addr},  32'h0);
    check_vec("rst_cmd_err", {31'h0, cmd_err},      32'h0);
    reset = 1'b1;
    repeat (10) @(negedge clock);

    // Read at 0x000004 streaming 64 bits: words at 4 then 8, refetch of 0xC
    base = en_cnt; ebase = err_cnt;
    select();
    spi_xfer(32'h03000004, 32, rx);
    check_vec("busy_hdr", {31'h0, busy}, 32'h1);
    read_check("rd4_data", 64'hAABBCCDD_11223344, 8);
    deselect();
    check_vec("rd4_nfetch", en_cnt - base, 3);
    check_vec("rd4_addr0", {8'h0, addr_log[base]},     32'h000004);
    check_vec("rd4_addr1", {8'h0, addr_log[base + 1]}, 32'h000008);
    check_vec("rd4_noerr", err_cnt - ebase, 0);
    check_vec("idle_busy", {31'h0, busy}, 32'h0);
    check_vec("idle_miso", {31'h0, bus.spi_miso}, 32'h1);

    // Address wrap: FFFFFE ignores low bits, streams FFFFFC then 000000
    base = en_cnt;
    select();
    spi_xfer(32'h03FFFFFE, 32, rx);
    read_check("wrap_data", 64'h21436587_A9CBED0F, 8);
    deselect();
    check_vec("wrap_addr0", {8'h0, addr_log[base]},     32'hFFFFFC);
    check_vec("wrap_addr1", {8'h0, addr_log[base + 1]}, 32'h000000);

    // Bad opcode: one error pulse, no fetch, MISO idles high
    base = en_cnt; ebase = err_cnt;
    select();
    spi_xfer(32'h9F, 8, rx);
    spi_xfer(32'h0, 16, rx);
    check_vec("bad_miso", rx, 32'h0000FFFF);
    deselect();
    check_vec("bad_err", err_cnt - ebase, 1);
    check_vec("bad_nofetch", en_cnt - base, 0);
    base = en_cnt;
    select();
    spi_xfer(32'h03000008, 32, rx);
    read_check("after_bad", 64'h11223344_00000000, 4);
    deselect();
    check_vec("after_bad_addr", {8'h0, addr_log[base]}, 32'h000008);

    // Aborted address phase then a fresh read at 0x10
    base = en_cnt;
    select();
    spi_xfer(32'h03000, 20, rx);
    deselect();
    check_vec("abort_nofetch", en_cnt - base, 0);
    check_vec("abort_busy", {31'h0, busy}, 32'h0);
    select();
    spi_xfer(32'h03000010, 32, rx);
    read_check("rd10_data", 64'h5AC33CA5_00000000 ^ 64'h00FFFF00_00000000 ^ 64'h00FFFF00_00000000, 0);
    read_check("rd10_data", 64'h5A3CC3A5_00000000, 4);
    deselect();
    check_vec("rd10_nfetch", en_cnt - base, 2);
    check_vec("rd10_addr", {8'h0, addr_log[base]}, 32'h000010);

    // Reset during the data phase, released with ss still low
    select();
    spi_xfer(32'h03000004, 32, rx);
    read_check("pre_rst", 64'hAABB0000_00000000, 2);
    reset = 1'b0;
    #1;
    check_vec("rst_mid_miso", {31'h0, bus.spi_miso}, 32'h1);
    check_vec("rst_mid_busy", {31'h0, busy},         32'h0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (20) @(negedge clock);
    check_vec("no_resume", {31'h0, busy}, 32'h0);
    base = en_cnt;
    deselect();
    select();
    spi_xfer(32'h03000008, 32, rx);
    read_check("post_rst", 64'h11223344_00000000, 4);
    deselect();
    check_vec("post_rst_addr", {8'h0, addr_log[base]}, 32'h000008);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
